// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, NOP encoding and queue entry layout for the fetch stage
package fetch_pkg;
   localparam int INST_W_DEF = 32;
   localparam int PC_W_DEF   = 32;
   localparam logic [INST_W_DEF-1:0] NOP_INST = '0;

   typedef struct packed {
      logic [INST_W_DEF-1:0] inst;
      logic [PC_W_DEF-1:0]   pc_n;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous prefetch FIFO with flush; push and pop together at full are legal
module fetch_queue
   import fetch_pkg::*;
#(
   parameter  int WIDTH = INST_W_DEF + PC_W_DEF,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, word-addressed instruction ROM and prefetch queue feeding decode
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                PC_W       = PC_W_DEF,
   parameter int                INST_W     = INST_W_DEF,
   parameter int                IMEM_DEPTH = 1024,
   parameter int                FQ_DEPTH   = 4,
   parameter logic [PC_W-1:0]   RESET_PC   = '0,
   parameter string             INIT_FILE  = "",
   localparam int               IMEM_AW    = $clog2(IMEM_DEPTH),
   localparam int               FQ_CW      = $clog2(FQ_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              is_jmp,
   input  logic [PC_W-1:0]   pc_jmp,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc_n,
   output logic [FQ_CW-1:0]  fq_count
);
   logic [INST_W-1:0] rom [IMEM_DEPTH];
   logic [PC_W-1:0]   fetch_pc;
   logic [PC_W-1:0]   pc_inc;
   logic [INST_W-1:0] rom_word;
   logic              pop;
   logic              push;
   logic              q_empty;
   logic              q_full;

   // Upper PC bits are ignored so fetch addresses wrap modulo IMEM_DEPTH.
   assign rom_word = rom[fetch_pc[IMEM_AW-1:0]];
   assign pc_inc   = fetch_pc + PC_W'(1);
   assign pop      = out_valid & out_ready;
   assign push     = ~is_jmp & (~q_full | pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      fetch_pc <= RESET_PC;
      else if (is_jmp) fetch_pc <= pc_jmp;
      else if (push)   fetch_pc <= pc_inc;
   end

   fetch_queue #(
      .WIDTH(INST_W + PC_W),
      .DEPTH(FQ_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (is_jmp),
      .din   ({rom_word, pc_inc}),
      .dout  ({out_inst, out_pc_n}),
      .empty (q_empty),
      .full  (q_full),
      .count (fq_count)
   );

   assign out_valid = ~q_empty;
endmodule
